// File: rtl/sort4_pkg.sv
// Shared types and helpers for the 4-word streaming sort controller.
package sort4_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int NL         = 4;
    localparam int PAD_MAX_DW = 64;

    // Padding sorts after every real word, so short blocks only ever
    // emit their real words from the low end of the sorted result.
    function automatic logic [PAD_MAX_DW-1:0] pad_word();
        pad_word = '1;
    endfunction

endpackage

// File: rtl/sort4_stream_ctrl_sort4number.sv
// Combinational 4-input ascending sorter (lane 0 = minimum).
module sort4number #(
    parameter int DW = 8
) (
    input  logic [4*DW-1:0] inp,
    output logic [4*DW-1:0] outp
);

    logic [DW-1:0] v [4];
    logic [DW-1:0] t;

    // Five compare-exchange stages: (0,1) (2,3) (0,2) (1,3) (1,2).
    always_comb begin
        t = '0;
        for (int k = 0; k < 4; k++) v[k] = inp[DW*k +: DW];
        if (v[0] > v[1]) begin t = v[0]; v[0] = v[1]; v[1] = t; end
        if (v[2] > v[3]) begin t = v[2]; v[2] = v[3]; v[3] = t; end
        if (v[0] > v[2]) begin t = v[0]; v[0] = v[2]; v[2] = t; end
        if (v[1] > v[3]) begin t = v[1]; v[1] = v[3]; v[3] = t; end
        if (v[1] > v[2]) begin t = v[1]; v[1] = v[2]; v[2] = t; end
        outp = {v[3], v[2], v[1], v[0]};
    end

endmodule

// File: rtl/sort4_stream_ctrl.sv
// Gathers up to four stream words, sorts them, replays the real words ascending.
//
// state | meaning
// FILL  | accepting words into slots; in_last or a 4th word closes the block
// SORT  | one cycle: capture sorter output into obuf
// DRAIN | emit obuf[0..n-1] on the output handshake, then back to FILL
module sort4_stream_ctrl
    import sort4_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy
);

    state_t        state_q, state_d;
    logic [1:0]    wr_cnt;
    logic [1:0]    rd_idx;
    logic [2:0]    n;
    logic          last_flag;
    logic [DW-1:0] slot [NL];
    logic [DW-1:0] obuf [NL];

    logic [NL*DW-1:0] sort_in, sort_out;
    logic [DW-1:0]    pad_val;
    logic             in_hs, close_blk, last_rd;

    assign pad_val   = DW'(pad_word());
    assign in_hs     = in_valid & in_ready;
    assign close_blk = in_hs & ((wr_cnt == 2'd3) | in_last);
    assign last_rd   = ({1'b0, rd_idx} == (n - 3'd1));
    assign sort_in   = {slot[3], slot[2], slot[1], slot[0]};

    sort4number #(.DW(DW)) u_sort (
        .inp  (sort_in),
        .outp (sort_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = obuf[rd_idx];
        busy      = 1'b1;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                busy     = (wr_cnt != 2'd0);
                if (close_blk) state_d = SORT;
            end
            SORT: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = last_flag & last_rd;
                if (out_ready && last_rd) state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Slot fill, padding, sorted capture and read pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_idx    <= '0;
            n         <= '0;
            last_flag <= 1'b0;
            for (int k = 0; k < NL; k++) begin
                slot[k] <= '0;
                obuf[k] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (in_hs) begin
                        slot[wr_cnt] <= in_data;
                        if (close_blk) begin
                            n         <= {1'b0, wr_cnt} + 3'd1;
                            last_flag <= in_last;
                            for (int k = 0; k < NL; k++) begin
                                if (k > int'(wr_cnt)) slot[k] <= pad_val;
                            end
                        end else begin
                            wr_cnt <= wr_cnt + 2'd1;
                        end
                    end
                end
                SORT: begin
                    for (int k = 0; k < NL; k++) obuf[k] <= sort_out[DW*k +: DW];
                    wr_cnt <= '0;
                    rd_idx <= '0;
                end
                DRAIN: begin
                    if (out_ready && !last_rd) rd_idx <= rd_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_stream_ctrl.sv
// Self-checking bench for sort4_stream_ctrl: directed blocks plus random blocks
// compared against a sorted-queue reference.
module tb_sort4_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

    sort4_stream_ctrl #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer cnt words; returns at the negedge of the SORT cycle.
    task automatic push(input logic [7:0] w [4], input int cnt, input bit last, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    chk("gap_ready", in_ready, 1);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                end
            end
            @(negedge clk);
            chk("fill_ready", in_ready, 1);
            chk("fill_busy", busy, (i > 0));
            chk("fill_nvalid", out_valid, 0);
            in_data  = w[i];
            in_valid = 1'b1;
            in_last  = last && (i == cnt - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("sort_valid", out_valid, 0);
        chk("sort_ready", in_ready, 0);
        chk("sort_busy", busy, 1);
    endtask

    // Consume stop_after outputs, comparing against the ascending real words.
    task automatic drain(input logic [7:0] w [4], input int cnt, input bit last,
                         input int stall, input bit rnd_ready, input bit rnd_in,
                         input int stop_after);
        logic [7:0] q [$];
        int idx   = 0;
        int guard = 0;
        for (int i = 0; i < cnt; i++) q.push_back(w[i]);
        q.sort();
        while (idx < stop_after && guard < 100) begin
            @(negedge clk);
            guard++;
            if (guard <= stall)  out_ready = 1'b0;
            else if (rnd_ready)  out_ready = 1'($urandom);
            else                 out_ready = 1'b1;
            if (rnd_in) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, q[idx]);
            chk("drain_last", out_last, (last && idx == cnt - 1));
            chk("drain_ready", in_ready, 0);
            if (out_ready) idx++;
        end
        chk("drain_count", idx, stop_after);
    endtask

    // Cycle after the final output handshake: back in FILL, nothing retained.
    task automatic after_block();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'($urandom);
        chk("idle_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    task automatic run_block(input logic [7:0] w [4], input int cnt, input bit last,
                             input int stall, input bit rnd_ready, input bit rnd_in, input bit gaps);
        push(w, cnt, last, gaps);
        drain(w, cnt, last, stall, rnd_ready, rnd_in, cnt);
        after_block();
    endtask

    initial begin
        logic [7:0] w [4];
        int         cnt;
        bit         last;

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);

        // full block, no last, back-to-back outputs
        w = '{8'h30, 8'h10, 8'h40, 8'h20};
        run_block(w, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // two-word packet
        w = '{8'h09, 8'h03, 8'h00, 8'h00};
        run_block(w, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // real all-ones word ties with padding
        w = '{8'hFF, 8'h01, 8'h00, 8'h00};
        run_block(w, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // single-word packet
        w = '{8'h55, 8'h00, 8'h00, 8'h00};
        run_block(w, 1, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // backpressure on the first output
        w = '{8'h04, 8'h03, 8'h02, 8'h01};
        run_block(w, 4, 1'b0, 3, 1'b0, 1'b0, 1'b0);

        // equal words, input noise during drain
        w = '{8'h07, 8'h07, 8'h07, 8'h07};
        run_block(w, 4, 1'b0, 0, 1'b0, 1'b1, 1'b0);

        // last on the 4th word
        w = '{8'hA0, 8'h0A, 8'h5A, 8'hA5};
        run_block(w, 4, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // reset after two output handshakes
        w = '{8'h66, 8'h77, 8'h88, 8'h99};
        push(w, 4, 1'b0, 1'b0);
        drain(w, 4, 1'b0, 0, 1'b0, 1'b0, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_last", out_last, 0);
        w = '{8'h22, 8'h11, 8'h44, 8'h33};
        run_block(w, 4, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // randomized blocks
        for (int b = 0; b < 30; b++) begin
            cnt  = $urandom_range(1, 4);
            last = (cnt < 4) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < 4; i++)
                w[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            run_block(w, cnt, last, $urandom_range(0, 2), 1'b1, 1'b1, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
